des_feistel_core: RTL

- Iterative DES Feistel datapath that sits directly downstream of the initial-permutation stage.
- Accepts one IP-permuted 64-bit block and runs the 16 Feistel rounds one per clock.
- The f-function (E-expansion, S-boxes, P) and the key schedule are external combinational blocks. This core drives the round index and right half to them and consumes the f result.
- Applies the final swap and final permutation (IP^-1) and presents the ciphertext/plaintext block with a valid/ready handshake.

---
 rtl/des_feistel_core_if.sv | 21 ++
 rtl/des_feistel_core.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/des_feistel_core_if.sv
// Block-stream interface for the DES Feistel core: IP-permuted block in,
// final-permuted block out, each with a valid/ready handshake.
interface des_feistel_core_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] din;
  logic        decrypt;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] dout;

  modport master (
    output in_valid, din, decrypt, out_ready,
    input  in_ready, out_valid, dout
  );

  modport slave (
    input  in_valid, din, decrypt, out_ready,
    output in_ready, out_valid, dout
  );
endinterface

// File: rtl/des_feistel_core.sv
// Iterative DES Feistel datapath: one round per clock using an external f-function
// and key schedule, then final swap and IP^-1 into a registered output block.
module des_feistel_core #(
  parameter int ROUNDS = 16
) (
  input  logic              clk,
  input  logic              rst,
  des_feistel_core_if.slave bus,
  output logic [3:0]        round_idx,
  output logic [31:0]       f_r,
  input  logic [31:0]       f_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [3:0] LAST_CNT = 4'(ROUNDS - 1);

  // IP^-1: row r, column c of the table picks preoutput bit 40-r+8*(c/2) (even c) or 8-r+8*(c/2) (odd c).
  function automatic logic [63:0] final_perm(input logic [63:0] pre);
    logic [63:0] res;
    int          src;
    int          dst;
    res = 64'h0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        dst = r * 8 + c + 1;
        src = ((c % 2) == 0) ? (40 - r + 8 * (c / 2)) : (8 - r + 8 * (c / 2));
        res[6'(64 - dst)] = pre[6'(64 - src)];
      end
    end
    return res;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] l_q, l_d;
  logic [31:0] r_q, r_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        dir_q, dir_d;
  logic [63:0] dout_q, dout_d;
  logic        out_valid_q, out_valid_d;
  logic        in_ready_q, in_ready_d;
  logic [3:0]  round_idx_q, round_idx_d;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign round_idx     = round_idx_q;
  assign f_r           = r_q;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    l_d         = l_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    dout_d      = dout_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          l_d        = bus.din[63:32];
          r_d        = bus.din[31:0];
          cnt_d      = 4'd0;
          dir_d      = bus.decrypt;
          in_ready_d = 1'b0;
          state_d    = ROUND;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      ROUND: begin
        l_d = r_q;
        r_d = l_q ^ f_out;
        if (cnt_q == LAST_CNT) begin
          // Preoutput is R16||L16, i.e. the final swap is folded in here.
          dout_d      = final_perm({l_q ^ f_out, r_q});
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase

    if (state_d == ROUND) begin
      if (dir_d) begin
        round_idx_d = 4'd15 - cnt_d;
      end else begin
        round_idx_d = cnt_d;
      end
    end else begin
      round_idx_d = 4'd0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      l_q         <= 32'h0;
      r_q         <= 32'h0;
      cnt_q       <= 4'd0;
      dir_q       <= 1'b0;
      dout_q      <= 64'h0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      round_idx_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      l_q         <= l_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      round_idx_q <= round_idx_d;
    end
  end

endmodule
